// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with an iterative shift-add multiplier and a persistent
// N/Z/C/V flag register. Single-cycle ops register on the accept edge; MUL/MULH finish WIDTH edges later.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fn,
  input  logic             use_cflag,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             alu_z,
  output logic             alu_c,
  output logic             alu_n,
  output logic             alu_v,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MASK = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_MULH = 4'd14;
  localparam logic [3:0] OP_CMP  = 4'd15;

  logic                 busy_r;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     out_r;
  logic                 z_r, c_r, n_r, v_r;
  logic [SHW-1:0]       mul_cnt_r;
  logic                 mul_hi_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;

  logic                 in_ready_s;
  logic                 accept_s;
  logic                 is_mul_s;
  logic                 load_single_s;
  logic                 start_mul_s;
  logic                 mul_done_s;
  logic                 cin_s;
  logic [SHW-1:0]       sh_s;
  logic                 sh_nz_s;
  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       sub_s;
  logic [WIDTH:0]       shl_s;
  logic [WIDTH:0]       shr_s;
  logic signed [WIDTH:0] asr_s;
  logic [2*WIDTH-1:0]   rol_s;
  logic [2*WIDTH-1:0]   ror_s;
  logic [2*WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]     res_s;
  logic [WIDTH-1:0]     flag_src_s;
  logic [WIDTH-1:0]     mul_res_s;
  logic                 mul_ovf_s;
  logic                 c_s;
  logic                 v_s;

  assign in_ready_s    = !busy_r && (!out_valid_r || out_ready);
  assign accept_s      = in_valid && in_ready_s;
  assign is_mul_s      = (fn == OP_MUL) || (fn == OP_MULH);
  assign load_single_s = accept_s && !is_mul_s;
  assign start_mul_s   = accept_s && is_mul_s;

  assign sh_s    = b[SHW-1:0];
  assign sh_nz_s = (sh_s != {SHW{1'b0}});

  // Carry-in source: only the carry-chained ops look at it, the rest see zero.
  always_comb begin
    cin_s = 1'b0;
    if ((fn == OP_ADDC) || (fn == OP_SUBC)) begin
      cin_s = use_cflag ? c_r : carry_in;
    end else begin
      cin_s = 1'b0;
    end
  end

  // Extra bit on each shifter catches the last bit shifted out; amount 0 leaves it clear.
  assign add_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
  assign sub_s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_s};
  assign shl_s = {1'b0, a} << sh_s;
  assign shr_s = {a, 1'b0} >> sh_s;
  assign asr_s = $signed({a, 1'b0}) >>> sh_s;
  assign rol_s = {a, a} << sh_s;
  assign ror_s = {a, a} >> sh_s;

  // Single-cycle result, carry and overflow selection.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (fn)
      OP_ADD, OP_ADDC: begin
        res_s = add_s[WIDTH-1:0];
        c_s   = add_s[WIDTH];
        v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SUBC: begin
        res_s = sub_s[WIDTH-1:0];
        c_s   = sub_s[WIDTH];
        v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_CMP: begin
        res_s = a;
        c_s   = sub_s[WIDTH];
        v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_s = a & b;
      OP_OR:   res_s = a | b;
      OP_XOR:  res_s = a ^ b;
      OP_MASK: res_s = a & ~b;
      OP_SHL: begin
        res_s = shl_s[WIDTH-1:0];
        c_s   = shl_s[WIDTH];
      end
      OP_SHR: begin
        res_s = shr_s[WIDTH:1];
        c_s   = shr_s[0];
      end
      OP_ASR: begin
        res_s = asr_s[WIDTH:1];
        c_s   = asr_s[0];
      end
      OP_ROL: begin
        res_s = rol_s[2*WIDTH-1:WIDTH];
        c_s   = sh_nz_s && rol_s[WIDTH];
      end
      OP_ROR: begin
        res_s = ror_s[WIDTH-1:0];
        c_s   = sh_nz_s && ror_s[WIDTH-1];
      end
      default: begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
      end
    endcase
  end

  // CMP reports N/Z of the difference while passing A through.
  assign flag_src_s = (fn == OP_CMP) ? sub_s[WIDTH-1:0] : res_s;

  assign acc_nxt_s  = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
  assign mul_done_s = busy_r && (mul_cnt_r == SHW'(WIDTH - 1));
  assign mul_res_s  = mul_hi_r ? acc_nxt_s[2*WIDTH-1:WIDTH] : acc_nxt_s[WIDTH-1:0];
  assign mul_ovf_s  = (acc_nxt_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});

  // Shift-add multiplier: one partial product per cycle, final add folded into the load edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      mul_cnt_r <= {SHW{1'b0}};
      mul_hi_r  <= 1'b0;
      acc_r     <= {(2*WIDTH){1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
    end else if (start_mul_s) begin
      busy_r    <= 1'b1;
      mul_cnt_r <= {SHW{1'b0}};
      mul_hi_r  <= (fn == OP_MULH);
      acc_r     <= {(2*WIDTH){1'b0}};
      mcand_r   <= {{WIDTH{1'b0}}, a};
      mplier_r  <= b;
    end else if (busy_r) begin
      busy_r    <= !mul_done_s;
      mul_cnt_r <= mul_cnt_r + SHW'(1);
      acc_r     <= acc_nxt_s;
      mcand_r   <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r  <= {1'b0, mplier_r[WIDTH-1:1]};
    end
  end

  // Output and flag register: loads on a result, otherwise drains on out_ready and keeps its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_r       <= {WIDTH{1'b0}};
      z_r         <= 1'b0;
      c_r         <= 1'b0;
      n_r         <= 1'b0;
      v_r         <= 1'b0;
    end else if (load_single_s) begin
      out_valid_r <= 1'b1;
      out_r       <= res_s;
      z_r         <= (flag_src_s == {WIDTH{1'b0}});
      c_r         <= c_s;
      n_r         <= flag_src_s[WIDTH-1];
      v_r         <= v_s;
    end else if (mul_done_s) begin
      out_valid_r <= 1'b1;
      out_r       <= mul_res_s;
      z_r         <= (mul_res_s == {WIDTH{1'b0}});
      c_r         <= mul_ovf_s;
      n_r         <= mul_res_s[WIDTH-1];
      v_r         <= mul_ovf_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign alu_z     = z_r;
  assign alu_c     = c_r;
  assign alu_n     = n_r;
  assign alu_v     = v_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: vector table, hand sequences and randomized checks against an integer reference model.
// Instantiates an 8-bit and a 16-bit alu_pipe.
`timescale 1ns/1ps
module tb_alu_pipe;

  localparam logic [3:0] F_ADD = 4'd0,  F_ADDC = 4'd1,  F_SUB = 4'd2,  F_SUBC = 4'd3;
  localparam logic [3:0] F_AND = 4'd4,  F_OR   = 4'd5,  F_XOR = 4'd6,  F_MASK = 4'd7;
  localparam logic [3:0] F_SHL = 4'd8,  F_SHR  = 4'd9,  F_ASR = 4'd10, F_ROL  = 4'd11;
  localparam logic [3:0] F_ROR = 4'd12, F_MUL  = 4'd13, F_MULH = 4'd14, F_CMP = 4'd15;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       in_valid8, in_ready8, uc8, ci8, out_valid8, out_ready8, busy8, z8, c8, n8, v8;
  logic [7:0] a8, b8, out8;
  logic [3:0] fn8;

  logic        in_valid16, in_ready16, uc16, ci16, out_valid16, out_ready16, busy16, z16, c16, n16, v16;
  logic [15:0] a16, b16, out16;
  logic [3:0]  fn16;

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .fn(fn8), .use_cflag(uc8), .carry_in(ci8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .alu_z(z8), .alu_c(c8), .alu_n(n8), .alu_v(v8), .busy(busy8)
  );

  alu_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
    .fn(fn16), .use_cflag(uc16), .carry_in(ci16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out(out16), .alu_z(z16), .alu_c(c16), .alu_n(n16), .alu_v(v16), .busy(busy16)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] f;
    logic [7:0] x;
    logic [7:0] y;
    logic       uc;
    logic       ci;
    logic [7:0] eo;
    logic [3:0] ef;   // {Z, C, N, V}
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic straight from the opcode definitions; returns {out, Z, C, N, V}.
  function automatic logic [11:0] model8(input int f, input int x, input int y,
                                          input bit uc, input bit ci, input bit cf);
    int cin, t, r, fv, sh, sx, c, v, p;
    cin = (f == 1 || f == 3) ? (uc ? int'(cf) : int'(ci)) : 0;
    sh = y % 8;
    sx = (x >= 128) ? x - 256 : x;
    c = 0; v = 0; r = 0;
    case (f)
      0, 1: begin
        t = x + y + cin; r = t % 256; c = (t >= 256) ? 1 : 0;
        v = (((x >= 128) == (y >= 128)) && ((r >= 128) != (x >= 128))) ? 1 : 0;
      end
      2, 3, 15: begin
        t = x - y - cin; r = (t + 256) % 256; c = (t < 0) ? 1 : 0;
        v = (((x >= 128) != (y >= 128)) && ((r >= 128) != (x >= 128))) ? 1 : 0;
      end
      4: r = x & y;
      5: r = x | y;
      6: r = x ^ y;
      7: r = x & (255 - y);
      8: begin r = (x * (1 << sh)) % 256; c = (sh != 0) ? ((x >> (8 - sh)) & 1) : 0; end
      9: begin r = x >> sh; c = (sh != 0) ? ((x >> (sh - 1)) & 1) : 0; end
      10: begin r = (sx >>> sh) & 255; c = (sh != 0) ? ((sx >>> (sh - 1)) & 1) : 0; end
      11: begin r = ((x << sh) | (x >> (8 - sh))) % 256; c = (sh != 0) ? (r & 1) : 0; end
      12: begin r = ((x >> sh) | (x << (8 - sh))) % 256; c = (sh != 0) ? ((r >> 7) & 1) : 0; end
      default: begin
        p = x * y; r = (f == 13) ? p % 256 : p / 256;
        c = (p / 256 != 0) ? 1 : 0; v = c;
      end
    endcase
    fv = r;
    if (f == 15) r = x;
    return {r[7:0], (fv == 0), c[0], (fv >= 128), v[0]};
  endfunction

  task automatic send8(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y,
                       input logic uc, input logic ci);
    bit ok;
    int n;
    fn8 = f; a8 = x; b8 = y; uc8 = uc; ci8 = ci; in_valid8 = 1'b1;
    ok = 1'b0; n = 0;
    #1;
    while (!ok && n < 40) begin
      ok = in_ready8;
      @(posedge clk); #1;
      n++;
    end
    in_valid8 = 1'b0;
    chk("accept8", ok, 1);
  endtask

  task automatic send16(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y);
    bit ok;
    int n;
    fn16 = f; a16 = x; b16 = y; uc16 = 1'b0; ci16 = 1'b0; in_valid16 = 1'b1;
    ok = 1'b0; n = 0;
    #1;
    while (!ok && n < 40) begin
      ok = in_ready16;
      @(posedge clk); #1;
      n++;
    end
    in_valid16 = 1'b0;
    chk("accept16", ok, 1);
  endtask

  task automatic wait_out8(output int cycles, output bit ir_seen);
    cycles = 0;
    ir_seen = 1'b0;
    while (out_valid8 !== 1'b1 && cycles < 40) begin
      if (in_ready8 === 1'b1) ir_seen = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    if (out_valid8 !== 1'b1) chk("out_valid8_wait", out_valid8, 1);
  endtask

  task automatic run_chk8(input string name, input logic [3:0] f, input logic [7:0] x,
                          input logic [7:0] y, input logic uc, input logic ci,
                          input logic [7:0] eo, input logic [3:0] ef);
    int cyc;
    bit irs;
    out_ready8 = 1'b1;
    send8(f, x, y, uc, ci);
    wait_out8(cyc, irs);
    chk({name, "_out"}, out8, eo);
    chk({name, "_flags"}, {z8, c8, n8, v8}, ef);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit irs;
    bit seen;
    bit model_c;
    logic [11:0] exp;
    logic [3:0] rf;
    logic [7:0] rx, ry;
    logic ruc, rci;

    vecs[0]  = '{F_ADD,  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1100};
    vecs[1]  = '{F_ADD,  8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 4'b0000};
    vecs[2]  = '{F_SUB,  8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 4'b0001};
    vecs[3]  = '{F_CMP,  8'h05, 8'h07, 1'b0, 1'b0, 8'h05, 4'b0110};
    vecs[4]  = '{F_ASR,  8'h90, 8'h03, 1'b0, 1'b0, 8'hF2, 4'b0010};
    vecs[5]  = '{F_SHL,  8'h81, 8'h01, 1'b0, 1'b0, 8'h02, 4'b0100};
    vecs[6]  = '{F_ROR,  8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 4'b0000};
    vecs[7]  = '{F_ROL,  8'h81, 8'h01, 1'b0, 1'b0, 8'h03, 4'b0100};
    vecs[8]  = '{F_SHR,  8'h81, 8'h01, 1'b0, 1'b0, 8'h40, 4'b0100};
    vecs[9]  = '{F_AND,  8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 4'b0000};
    vecs[10] = '{F_OR,   8'hF0, 8'h3C, 1'b0, 1'b0, 8'hFC, 4'b0010};
    vecs[11] = '{F_XOR,  8'hF0, 8'h3C, 1'b0, 1'b0, 8'hCC, 4'b0010};
    vecs[12] = '{F_MASK, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'hC0, 4'b0010};
    vecs[13] = '{F_ADDC, 8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 4'b0011};
    vecs[14] = '{F_SUBC, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 4'b0110};
    vecs[15] = '{F_MUL,  8'h10, 8'h20, 1'b0, 1'b0, 8'h00, 4'b1101};
    vecs[16] = '{F_MULH, 8'h10, 8'h20, 1'b0, 1'b0, 8'h02, 4'b0101};
    vecs[17] = '{F_ASR,  8'h90, 8'h00, 1'b0, 1'b0, 8'h90, 4'b0010};
    vecs[18] = '{F_ROL,  8'h81, 8'h00, 1'b0, 1'b0, 8'h81, 4'b0010};

    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; fn8 = 4'd0; uc8 = 1'b0; ci8 = 1'b0; out_ready8 = 1'b0;
    in_valid16 = 1'b0; a16 = 16'h0; b16 = 16'h0; fn16 = 4'd0; uc16 = 1'b0; ci16 = 1'b0; out_ready16 = 1'b0;
    #12;
    chk("rst_in_ready8", in_ready8, 1);
    chk("rst_out_valid8", out_valid8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_out8", out8, 0);
    chk("rst_flags8", {z8, c8, n8, v8}, 0);
    chk("rst_in_ready16", in_ready16, 1);
    chk("rst_out_valid16", out_valid16, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      run_chk8($sformatf("vec%0d", i), vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].uc, vecs[i].ci,
               vecs[i].eo, vecs[i].ef);
    end

    // Back-to-back 16-bit add built from ADD then ADDC, first with the flag carry, then with the port.
    out_ready8 = 1'b1;
    send8(F_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
    chk("b2b_add_out", out8, 8'h00);
    chk("b2b_add_c", c8, 1);
    chk("b2b_add_valid", out_valid8, 1);
    send8(F_ADDC, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("b2b_addc_cf_out", out8, 8'h01);
    chk("b2b_addc_cf_c", c8, 0);
    chk("b2b_addc_cf_valid", out_valid8, 1);
    send8(F_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
    send8(F_ADDC, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("b2b_addc_port_out", out8, 8'h00);
    chk("b2b_addc_port_flags", {z8, c8, n8, v8}, 4'b1000);

    // Multiplier latency and in_ready blackout.
    send8(F_MUL, 8'h10, 8'h20, 1'b0, 1'b0);
    chk("mul_busy", busy8, 1);
    chk("mul_in_ready", in_ready8, 0);
    wait_out8(cyc, irs);
    chk("mul_latency", cyc, 8);
    chk("mul_in_ready_low", irs, 0);
    chk("mul_out", out8, 8'h00);
    chk("mul_flags", {z8, c8, n8, v8}, 4'b1101);
    chk("mul_busy_done", busy8, 0);

    // Reset on the fourth cycle of a multiply aborts it.
    send8(F_MUL, 8'h10, 8'h20, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_valid", out_valid8, 0);
    chk("abort_flags", {z8, c8, n8, v8}, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      if (out_valid8 === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_result", seen, 0);
    chk("abort_in_ready", in_ready8, 1);

    // 16-bit: result held under back-pressure, pending XOR loads when the consumer accepts.
    out_ready16 = 1'b0;
    send16(F_ADD, 16'h7FFF, 16'h0001);
    chk("w16_add_out", out16, 16'h8000);
    chk("w16_add_flags", {z16, c16, n16, v16}, 4'b0011);
    repeat (3) begin @(posedge clk); #1; end
    chk("w16_hold_out", out16, 16'h8000);
    chk("w16_hold_v", v16, 1);
    chk("w16_hold_valid", out_valid16, 1);
    chk("w16_hold_in_ready", in_ready16, 0);
    fn16 = F_XOR; a16 = 16'h1234; b16 = 16'h00FF; in_valid16 = 1'b1;
    @(posedge clk); #1;
    chk("w16_pending_out", out16, 16'h8000);
    out_ready16 = 1'b1;
    #1;
    chk("w16_ready_rise", in_ready16, 1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    chk("w16_xor_out", out16, 16'h12CB);
    chk("w16_xor_valid", out_valid16, 1);
    chk("w16_xor_flags", {z16, c16, n16, v16}, 4'b0000);
    @(posedge clk); #1;
    chk("w16_drain_valid", out_valid16, 0);
    chk("w16_drain_keep", out16, 16'h12CB);

    // Randomized ops against the model, tracking the carry flag for chained ops.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_c = 1'b0;
    for (int i = 0; i < 150; i++) begin
      rf = 4'($urandom_range(0, 15));
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      ruc = 1'($urandom_range(0, 1));
      rci = 1'($urandom_range(0, 1));
      exp = model8(int'(rf), int'(rx), int'(ry), ruc, rci, model_c);
      run_chk8($sformatf("rand%0d_fn%0d", i, rf), rf, rx, ry, ruc, rci, exp[11:4], exp[3:0]);
      model_c = exp[2];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
